// File: rtl/multiply_by_d_csd_pipe.sv
// CSD z*d for BKM digits d in {-1,0,1}^2, exact W+1-digit results; STAGES cycles latency, one beat/cycle.
// Global stall: in_ready = ~out_valid | out_ready. Define MULTIPLY_BY_D_CSD_PIPE_CONJ_EN to add conj_in (z*conj(d)).
module multiply_by_d_csd_pipe #(
    parameter int W      = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       d_x,
    input  logic [1:0]       d_y,
    input  logic [2*W-1:0]   x_in,
    input  logic [2*W-1:0]   y_in,
`ifdef MULTIPLY_BY_D_CSD_PIPE_CONJ_EN
    input  logic             conj_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W+1:0]   x_out,
    output logic [2*W+1:0]   y_out,
    output logic             d_err
);

    localparam int DW = 2 * W;
    localparam int OW = 2 * W + 2;

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("multiply_by_d_csd_pipe: STAGES must be in 1..4");
        end
    endgenerate

    function automatic logic signed [2:0] dig(input logic [1:0] d);
        return $signed({2'b00, d[0]}) - $signed({2'b00, d[1]});
    endfunction

    function automatic logic [1:0] enc(input logic signed [2:0] v);
        if (v == 3'sb001)
            return 2'b01;
        else if (v == 3'sb111)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Two-step signed-digit add: the transfer choice for digit i looks at digit i-1,
    // so the interim digit plus incoming transfer always stays in {-1,0,1}.
    function automatic logic [OW-1:0] csd_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [OW-1:0]    res;
        logic signed [2:0] s;
        logic signed [2:0] t_in;
        logic signed [2:0] t_out;
        logic signed [2:0] wd;
        logic              lo_nonneg;
        res       = '0;
        t_in      = 3'sb000;
        lo_nonneg = 1'b1;
        for (int i = 0; i < W; i++) begin
            s     = dig(a[2*i +: 2]) + dig(b[2*i +: 2]);
            t_out = 3'sb000;
            wd    = 3'sb000;
            if (s == 3'sb010) begin
                t_out = 3'sb001;
            end else if (s == 3'sb110) begin
                t_out = 3'sb111;
            end else if (s == 3'sb001) begin
                t_out = lo_nonneg ? 3'sb001 : 3'sb000;
                wd    = lo_nonneg ? 3'sb111 : 3'sb001;
            end else if (s == 3'sb111) begin
                t_out = lo_nonneg ? 3'sb000 : 3'sb111;
                wd    = lo_nonneg ? 3'sb111 : 3'sb001;
            end
            res[2*i +: 2] = enc(wd + t_in);
            lo_nonneg     = (dig(a[2*i +: 2]) >= 3'sb000) && (dig(b[2*i +: 2]) >= 3'sb000);
            t_in          = t_out;
        end
        res[OW-1 -: 2] = enc(t_in);
        return res;
    endfunction

    logic [1:0]    w_dy;
    logic          w_err;
    logic          w_dx_nz;
    logic          w_dy_nz;
    logic          w_dx_neg;
    logic          w_dy_neg;
    logic [DW-1:0] w_xdx;
    logic [DW-1:0] w_ydx;
    logic [DW-1:0] w_xdy;
    logic [DW-1:0] w_nydy;
    logic [OW-1:0] w_x;
    logic [OW-1:0] w_y;

`ifdef MULTIPLY_BY_D_CSD_PIPE_CONJ_EN
    // 01 <-> 11 swaps sign; 00 and the illegal 10 pass through unchanged.
    assign w_dy = (conj_in && d_y[0]) ? (d_y ^ 2'b10) : d_y;
`else
    assign w_dy = d_y;
`endif

    assign w_err    = (d_x == 2'b10) || (w_dy == 2'b10);
    assign w_dx_nz  = d_x[0];
    assign w_dy_nz  = w_dy[0];
    assign w_dx_neg = d_x == 2'b11;
    assign w_dy_neg = w_dy == 2'b11;

    assign w_xdx  = w_dx_neg ? ~x_in : x_in;
    assign w_ydx  = w_dx_neg ? ~y_in : y_in;
    assign w_xdy  = w_dy_neg ? ~x_in : x_in;
    assign w_nydy = w_dy_neg ? y_in : ~y_in;

    always_comb begin
        w_x = '0;
        w_y = '0;
        if (!w_err) begin
            case ({w_dx_nz, w_dy_nz})
                2'b11: begin
                    w_x = csd_add(w_xdx, w_nydy);
                    w_y = csd_add(w_xdy, w_ydx);
                end
                2'b10: begin
                    w_x = {2'b00, w_xdx};
                    w_y = {2'b00, w_ydx};
                end
                2'b01: begin
                    w_x = {2'b00, w_nydy};
                    w_y = {2'b00, w_xdy};
                end
                default: begin
                    w_x = '0;
                    w_y = '0;
                end
            endcase
        end
    end

    logic          r_vld [STAGES];
    logic          r_err [STAGES];
    logic [OW-1:0] r_x   [STAGES];
    logic [OW-1:0] r_y   [STAGES];

    assign out_valid = r_vld[STAGES-1];
    assign in_ready  = ~out_valid | out_ready;
    assign x_out     = r_x[STAGES-1];
    assign y_out     = r_y[STAGES-1];
    assign d_err     = r_err[STAGES-1] & r_vld[STAGES-1];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_err[s] <= 1'b0;
                r_x[s]   <= '0;
                r_y[s]   <= '0;
            end
        end else if (in_ready) begin
            r_vld[0] <= in_valid;
            r_err[0] <= w_err;
            r_x[0]   <= w_x;
            r_y[0]   <= w_y;
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_err[s] <= r_err[s-1];
                r_x[s]   <= r_x[s-1];
                r_y[s]   <= r_y[s-1];
            end
        end
    end

endmodule

// File: tb/tb_multiply_by_d_csd_pipe.sv
// Directed bench for multiply_by_d_csd_pipe at W=8, STAGES=2: vector table, stalled stream, error stream, reset.
module tb_multiply_by_d_csd_pipe;

    localparam int W      = 8;
    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  d_x = 2'b00;
    logic [1:0]  d_y = 2'b00;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
`ifdef MULTIPLY_BY_D_CSD_PIPE_CONJ_EN
    logic        conj_in = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [17:0] x_out;
    logic [17:0] y_out;
    logic        d_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiply_by_d_csd_pipe #(.W(W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_x       (d_x),
        .d_y       (d_y),
        .x_in      (x_in),
        .y_in      (y_in),
`ifdef MULTIPLY_BY_D_CSD_PIPE_CONJ_EN
        .conj_in   (conj_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .d_err     (d_err)
    );

    typedef struct {
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic        conj;
        logic [15:0] x;
        logic [15:0] y;
        int          ex;
        int          ey;
        logic        eerr;
        logic        chk_bits;
        logic [17:0] exb;
        logic [17:0] eyb;
    } vec_t;

    vec_t vecs [14];

    function automatic int csd_val(input logic [17:0] v);
        int r = 0;
        for (int i = 0; i < 9; i++)
            r = r + ((v[2*i] ? 1 : 0) - (v[2*i+1] ? 1 : 0)) * (1 << i);
        return r;
    endfunction

    function automatic logic [15:0] to_csd(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < 8; i++)
            r[2*i] = n[i];
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_bits(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Sends one beat into an empty pipe with out_ready=1; starts and ends 1 time unit after a posedge.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        d_x = v.dx;
        d_y = v.dy;
        x_in = v.x;
        y_in = v.y;
`ifdef MULTIPLY_BY_D_CSD_PIPE_CONJ_EN
        conj_in = v.conj;
`endif
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, STAGES);
        chk({tag, "_xval"}, csd_val(x_out), v.ex);
        chk({tag, "_yval"}, csd_val(y_out), v.ey);
        chk({tag, "_err"}, int'(d_err), int'(v.eerr));
        if (v.chk_bits) begin
            chk_bits({tag, "_xbits"}, x_out, v.exb);
            chk_bits({tag, "_ybits"}, y_out, v.eyb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n, input int st_lo, input int st_hi, input int err_idx);
        int sent = 0;
        int got = 0;
        int extra = 0;
        logic held = 1'b0;
        logic saw_nr = 1'b0;
        logic [17:0] hx = '0;
        logic [17:0] hy = '0;
        logic he = 1'b0;
        for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
            out_ready = !(cyc >= st_lo && cyc <= st_hi);
            if (sent < n) begin
                in_valid = 1'b1;
                x_in = to_csd(sent + 1);
                y_in = to_csd(sent + 11);
                d_x = (sent == err_idx) ? 2'b10 : 2'b01;
                d_y = 2'b00;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!in_ready) saw_nr = 1'b1;
            if (out_valid && held) begin
                chk_bits("stall_x_stable", x_out, hx);
                chk_bits("stall_y_stable", y_out, hy);
                chk("stall_err_stable", int'(d_err), int'(he));
            end
            if (out_valid) begin
                if (out_ready) begin
                    chk("stream_x", csd_val(x_out), (got == err_idx) ? 0 : got + 1);
                    chk("stream_y", csd_val(y_out), (got == err_idx) ? 0 : got + 11);
                    chk("stream_err", int'(d_err), (got == err_idx) ? 1 : 0);
                    if (got == err_idx) chk_bits("stream_err_xbits", x_out, 18'h0);
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hx = x_out;
                    hy = y_out;
                    he = d_err;
                end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", sent, n);
        chk("stream_received", got, n);
        chk("stream_in_ready_dropped", int'(saw_nr), (st_lo <= st_hi) ? 1 : 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("stream_no_duplicates", extra, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b01, 2'b00, 1'b0, 16'h0011, 16'h0005,    5,    3, 1'b0, 1'b1, 18'h00011, 18'h00005};
        vecs[1]  = '{2'b11, 2'b01, 1'b0, 16'h0011, 16'h0005,   -8,    2, 1'b0, 1'b0, 18'h0, 18'h0};
        vecs[2]  = '{2'b01, 2'b01, 1'b0, 16'h5555, 16'h5555,    0,  510, 1'b0, 1'b0, 18'h0, 18'h0};
        vecs[3]  = '{2'b00, 2'b00, 1'b0, 16'h0011, 16'h0005,    0,    0, 1'b0, 1'b1, 18'h0, 18'h0};
        vecs[4]  = '{2'b00, 2'b01, 1'b0, 16'h0011, 16'h0005,   -3,    5, 1'b0, 1'b1, 18'h0FFFA, 18'h00011};
        vecs[5]  = '{2'b00, 2'b11, 1'b0, 16'h0011, 16'h0005,    3,   -5, 1'b0, 1'b1, 18'h00005, 18'h0FFEE};
        vecs[6]  = '{2'b11, 2'b00, 1'b0, 16'h0011, 16'h0005,   -5,   -3, 1'b0, 1'b1, 18'h0FFEE, 18'h0FFFA};
        vecs[7]  = '{2'b01, 2'b11, 1'b0, 16'h0011, 16'h0005,    8,   -2, 1'b0, 1'b0, 18'h0, 18'h0};
        vecs[8]  = '{2'b11, 2'b11, 1'b0, 16'h0011, 16'h0005,   -2,   -8, 1'b0, 1'b0, 18'h0, 18'h0};
        vecs[9]  = '{2'b10, 2'b00, 1'b0, 16'h0011, 16'h0005,    0,    0, 1'b1, 1'b1, 18'h0, 18'h0};
        vecs[10] = '{2'b01, 2'b10, 1'b0, 16'h0011, 16'h0005,    0,    0, 1'b1, 1'b1, 18'h0, 18'h0};
        vecs[11] = '{2'b11, 2'b11, 1'b0, 16'h8001, 16'hAAAA, -128,  382, 1'b0, 1'b0, 18'h0, 18'h0};
        vecs[12] = '{2'b01, 2'b01, 1'b0, 16'hAAAA, 16'hAAAA,    0, -510, 1'b0, 1'b0, 18'h0, 18'h0};
        vecs[13] = '{2'b11, 2'b11, 1'b0, 16'h5555, 16'h5555,    0, -510, 1'b0, 1'b0, 18'h0, 18'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_d_err", int'(d_err), 0);
        chk_bits("reset_x_out", x_out, 18'h0);
        chk_bits("reset_y_out", y_out, 18'h0);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 14; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef MULTIPLY_BY_D_CSD_PIPE_CONJ_EN
        run_vec('{2'b01, 2'b01, 1'b1, 16'h0011, 16'h0005, 8, -2, 1'b0, 1'b0, 18'h0, 18'h0}, "conj_pp");
        run_vec('{2'b01, 2'b10, 1'b1, 16'h0011, 16'h0005, 0, 0, 1'b1, 1'b1, 18'h0, 18'h0}, "conj_illegal");
        conj_in = 1'b0;
`endif

        run_stream(6, 3, 7, -1);
        run_stream(3, 100, -1, 1);

        // Reset with two beats in flight: pass 0 has the illegal beat at the output, pass 1 a normal one.
        for (int rp = 0; rp < 2; rp++) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            x_in = 16'h0011;
            y_in = 16'h0005;
            d_x = (rp == 0) ? 2'b10 : 2'b01;
            d_y = 2'b00;
            @(posedge clk);
            #1;
            d_x = 2'b01;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("rst_pre_valid", int'(out_valid), 1);
            if (rp == 0) chk("rst_pre_err", int'(d_err), 1);
            else         chk("rst_pre_x", csd_val(x_out), 5);
            #2;
            arst = 1'b1;
            #1;
            chk("rst_async_valid", int'(out_valid), 0);
            chk("rst_async_err", int'(d_err), 0);
            chk_bits("rst_async_x", x_out, 18'h0);
            chk_bits("rst_async_y", y_out, 18'h0);
            @(negedge clk);
            arst = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_release_in_ready", int'(in_ready), 1);
            begin
                int stale = 0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (out_valid) stale++;
                end
                chk("rst_no_stale_beats", stale, 0);
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
